// File: rtl/serial_add_sub_ctrl.sv
// rtl/serial_add_sub_ctrl.sv - bit-serial adder/subtractor with start/done handshake
//
// Purpose:
//    One full-adder cell, built from two half-adder cells plus an OR, is
//    time-shared across all WIDTH bit positions. The operands are processed
//    LSB first, and the carry between bit positions is held in a flop. This is
//    the area-minimal alternative to a ripple-carry adder: an operation takes
//    WIDTH+1 busy cycles, and the block accepts one operation per WIDTH+2 cycles.
//
// Optional feature:
//    SERIAL_ADD_SAT_EN - when defined, a result that overflows (two's
//    complement) is clamped to the maximum positive or minimum negative value.
//    When undefined, result is always the wrapped modulo-2^WIDTH value.
//
// Parameters:
//    WIDTH      operand/result width in bits, 2..32
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    start      operation request, sampled only in IDLE
//    mode       0 = A+B, 1 = A-B, sampled with start
//    A, B       operands, sampled with start
//    busy       high while an operation is in RUN or DONE
//    done       one-cycle pulse when result/cout/overflow are updated
//    result     sum/difference, held until the next operation completes
//    cout       final carry; in subtract mode 1 = no borrow (A >= B unsigned)
//    overflow   two's-complement overflow of the operation

module serial_add_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   // Bit position whose carry-out is the carry into the MSB.
   localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             carry_msb_in;

   // Shared full-adder cell: two half adders plus an OR of their carries.
   logic ha0_sum;
   logic ha0_carry;
   logic ha1_sum;
   logic ha1_carry;
   logic fa_sum;
   logic fa_carry;

   assign ha0_sum   = op_a[0] ^ op_b[0];
   assign ha0_carry = op_a[0] & op_b[0];
   assign ha1_sum   = ha0_sum ^ carry;
   assign ha1_carry = ha0_sum & carry;
   assign fa_sum    = ha1_sum;
   assign fa_carry  = ha0_carry | ha1_carry;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt == CNT_LAST) begin
               next_state = S_DONE;
            end
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // busy comes straight from the state register, so there is no path from
   // the inputs to this output.
   assign busy = (state != S_IDLE);

   // Datapath: operand shifters, carry flop, accumulator and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a         <= '0;
         op_b         <= '0;
         acc          <= '0;
         cnt          <= '0;
         carry        <= 1'b0;
         carry_msb_in <= 1'b0;
         done         <= 1'b0;
         result       <= '0;
         cout         <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_a  <= A;
                  // Subtraction is A + ~B + 1: invert B and seed the carry.
                  op_b  <= mode ? ~B : B;
                  carry <= mode;
                  cnt   <= '0;
                  acc   <= '0;
               end
            end
            S_RUN: begin
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               // Sum bits enter at the MSB and move down, so after WIDTH
               // shifts the first (LSB) sum bit has reached bit 0.
               acc   <= {fa_sum, acc[WIDTH-1:1]};
               carry <= fa_carry;
               if (cnt == CNT_MSB_IN) begin
                  carry_msb_in <= fa_carry;
               end
               cnt   <= cnt + CW'(1);
            end
            S_DONE: begin
`ifdef SERIAL_ADD_SAT_EN
               // On overflow the final carry equals the sign of the true
               // result, so it picks which end of the range to clamp to.
               if (carry_msb_in ^ carry) begin
                  result <= carry ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
               end else begin
                  result <= acc;
               end
`else
               result <= acc;
`endif
               cout     <= carry;
               overflow <= carry_msb_in ^ carry;
               done     <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// tb/tb_serial_add_sub_ctrl.sv - self-checking bench for serial_add_sub_ctrl (WIDTH 8 and 4)

module tb_serial_add_sub_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       st8 = 1'b0, md8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, co8, ov8;
   logic [7:0] res8;

   logic       st4 = 1'b0, md4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, co4, ov4;
   logic [3:0] res4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_add_sub_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .mode(md8), .A(a8), .B(b8),
      .busy(busy8), .done(done8), .result(res8), .cout(co8), .overflow(ov8)
   );

   serial_add_sub_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(st4), .mode(md4), .A(a4), .B(b4),
      .busy(busy4), .done(done4), .result(res4), .cout(co4), .overflow(ov4)
   );

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [7:0] b;
      logic       m;
      logic [7:0] r;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operand values.
   task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic m, output logic [31:0] r, output logic co,
                        output logic ov);
      longint ua, ub, md, half, sa, sb, sr, t;
      md   = longint'(1) << w;
      half = md / 2;
      ua   = longint'(a) % md;
      ub   = longint'(b) % md;
      t    = m ? (ua - ub + md) : (ua + ub);
      r    = 32'(t % md);
      co   = m ? (ua >= ub) : (ua + ub >= md);
      sa   = (ua >= half) ? ua - md : ua;
      sb   = (ub >= half) ? ub - md : ub;
      sr   = m ? (sa - sb) : (sa + sb);
      ov   = (sr >= half) || (sr < -half);
`ifdef SERIAL_ADD_SAT_EN
      if (ov) r = (sr >= half) ? 32'(half - 1) : 32'(half);
`endif
   endtask

   // Start one operation, scramble the inputs while busy, wait for done.
   // lat is the number of falling edges from the start edge to done.
   task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic m, output logic [31:0] r, output logic co,
                         output logic ov, output int lat, output int bcnt);
      r = '0; co = 1'b0; ov = 1'b0; lat = -1; bcnt = 0;
      @(negedge clk);
      if (w == 8) begin st8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; md8 = m; end
      else        begin st4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; md4 = m; end
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) begin
            st8 = 1'b0; st4 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); md8 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom); md4 = 1'($urandom);
         end
         if (w == 8) begin
            if (busy8) bcnt++;
            if (done8) begin lat = k; r = 32'(res8); co = co8; ov = ov8; break; end
         end else begin
            if (busy4) bcnt++;
            if (done4) begin lat = k; r = 32'(res4); co = co4; ov = ov4; break; end
         end
      end
   endtask

   logic [31:0] r, er;
   logic        co, ov, eco, eov;
   int          lat, bcnt;

   logic [7:0] va[0:40];
   logic [7:0] vb[0:40];
   logic       vm[0:40];

   initial begin
      tbl[0] = '{"add_100_27", 8'd100, 8'd27,  1'b0, 8'd127, 1'b0, 1'b0};
`ifdef SERIAL_ADD_SAT_EN
      tbl[1] = '{"add_ovf",    8'h7F,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1};
      tbl[3] = '{"sub_ovf",    8'h80,  8'h01,  1'b1, 8'h80,  1'b1, 1'b1};
      tbl[5] = '{"add_neg_ovf", 8'h80, 8'h80,  1'b0, 8'h80,  1'b1, 1'b1};
`else
      tbl[1] = '{"add_ovf",    8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1};
      tbl[3] = '{"sub_ovf",    8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1};
      tbl[5] = '{"add_neg_ovf", 8'h80, 8'h80,  1'b0, 8'h00,  1'b1, 1'b1};
`endif
      tbl[2] = '{"sub_0_1",    8'h00,  8'h01,  1'b1, 8'hFF,  1'b0, 1'b0};
      tbl[4] = '{"sub_equal",  8'h55,  8'h55,  1'b1, 8'h00,  1'b1, 1'b0};
      tbl[6] = '{"add_wrap",   8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b0};

      // Reset state
      #12;
      check("reset_busy", busy8, 0);
      check("reset_done", done8, 0);
      check("reset_result", res8, 0);
      check("reset_cout", co8, 0);
      check("reset_ovf", ov8, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table, then a nonzero result left behind for the reset test
      for (int i = 0; i < 7; i++) begin
         run_op(8, 32'(tbl[i].a), 32'(tbl[i].b), tbl[i].m, r, co, ov, lat, bcnt);
         check({tbl[i].name, "_result"}, r, tbl[i].r);
         check({tbl[i].name, "_cout"}, co, tbl[i].co);
         check({tbl[i].name, "_ovf"}, ov, tbl[i].ov);
         check({tbl[i].name, "_latency"}, lat, 10);
         check({tbl[i].name, "_busy_cycles"}, bcnt, 9);
      end
      run_op(8, 32'd100, 32'd27, 1'b0, r, co, ov, lat, bcnt);
      check("pre_reset_result", r, 127);

      // Reset in the middle of RUN
      @(negedge clk);
      st8 = 1'b1; a8 = 8'h64; b8 = 8'h1B; md8 = 1'b0;
      @(negedge clk);
      st8 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrun_rst_busy", busy8, 0);
      check("midrun_rst_done", done8, 0);
      check("midrun_rst_result", res8, 0);
      check("midrun_rst_cout", co8, 0);
      check("midrun_rst_ovf", ov8, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8, 32'h64, 32'h1B, 1'b0, r, co, ov, lat, bcnt);
      check("post_rst_result", r, 32'h7F);
      check("post_rst_cout", co, 0);
      check("post_rst_latency", lat, 10);

      // Handshake: start held high, operands changing every cycle
      for (int j = 0; j <= 40; j++) begin
         va[j] = 8'($urandom); vb[j] = 8'($urandom); vm[j] = 1'($urandom);
      end
      @(negedge clk);
      st8 = 1'b1; a8 = va[0]; b8 = vb[0]; md8 = vm[0];
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         // Sample reflects posedge j; accepts happen at edges 0, 10, 20, ...
         if (j >= 9 && ((j - 9) % 10) == 0) begin
            check("hs_done_pulse", done8, 1);
            model(8, 32'(va[j-9]), 32'(vb[j-9]), vm[j-9], er, eco, eov);
            check("hs_result", res8, er[7:0]);
            check("hs_cout", co8, eco);
            check("hs_ovf", ov8, eov);
         end else begin
            check("hs_done_low", done8, 0);
         end
         a8 = va[j+1]; b8 = vb[j+1]; md8 = vm[j+1];
      end
      st8 = 1'b0;
      repeat (12) @(negedge clk);

      // Random operands against the model
      for (int i = 0; i < 150; i++) begin
         logic [31:0] ra, rb;
         logic        rm;
         ra = 32'($urandom_range(255)); rb = 32'($urandom_range(255)); rm = 1'($urandom);
         model(8, ra, rb, rm, er, eco, eov);
         run_op(8, ra, rb, rm, r, co, ov, lat, bcnt);
         check("rand_result", r, er);
         check("rand_cout", co, eco);
         check("rand_ovf", ov, eov);
         check("rand_latency", lat, 10);
      end

      // Exhaustive WIDTH=4
      for (int m = 0; m < 2; m++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               model(4, 32'(a), 32'(b), 1'(m), er, eco, eov);
               run_op(4, 32'(a), 32'(b), 1'(m), r, co, ov, lat, bcnt);
               check("w4_result", r, er);
               check("w4_cout", co, eco);
               check("w4_ovf", ov, eov);
               check("w4_latency", lat, 6);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
